// File: rtl/uart_loader_ctrl.sv
// uart_loader_ctrl: UART frame boot loader into instruction memory; `LOADER_TIMEOUT_EN adds an inter-byte timeout
module uart_loader_ctrl #(
   parameter int ADDR_W = 16,
   parameter int TIMEOUT_CYC = 50000,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter logic [7:0] ACK_BYTE = 8'h4B,
   parameter logic [7:0] NAK_BYTE = 8'h45
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);
   typedef enum logic [2:0] {IDLE, ADDR_L, ADDR_H, LEN, DATA, CHK, RESP} state_t;
   state_t state;
   logic [7:0] addr_lo, left, acc;
   logic [1:0] bcnt;
   logic [23:0] sh;
   logic [ADDR_W-1:0] waddr;
   logic ok, tmo;
   assign done = tx_valid && tx_ready && ok;
   assign err = tx_valid && tx_ready && !ok;
`ifdef LOADER_TIMEOUT_EN
   logic [31:0] tcnt;
   assign tmo = tcnt == 32'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk)
      if (rst || rx_valid || state == IDLE || state == RESP) tcnt <= '0;
      else tcnt <= tcnt + 32'd1;
`else
   assign tmo = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr_lo <= '0;
         left <= '0;
         acc <= '0;
         bcnt <= '0;
         sh <= '0;
         waddr <= '0;
         ok <= 1'b0;
         tx_valid <= 1'b0;
         tx_data <= '0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         cpu_hold <= 1'b0;
         busy <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
               state <= ADDR_L;
               acc <= '0;
               bcnt <= '0;
               cpu_hold <= 1'b1;
               busy <= 1'b1;
            end
            RESP: if (tx_ready) begin
               state <= IDLE;
               tx_valid <= 1'b0;
               cpu_hold <= 1'b0;
               busy <= 1'b0;
            end
            default: if (rx_valid) begin
               acc <= acc ^ rx_data;
               case (state)
                  ADDR_L: begin
                     addr_lo <= rx_data;
                     state <= ADDR_H;
                  end
                  ADDR_H: begin
                     waddr <= ADDR_W'({rx_data, addr_lo});
                     state <= LEN;
                  end
                  LEN: begin
                     left <= rx_data;
                     state <= DATA;
                  end
                  DATA: begin
                     bcnt <= bcnt + 2'd1;
                     sh <= {rx_data, sh[23:8]};
                     if (bcnt == 2'd3) begin
                        mem_we <= 1'b1;
                        mem_addr <= waddr;
                        mem_wdata <= {rx_data, sh};
                        waddr <= waddr + 1'b1;
                        left <= left - 8'd1;
                        if (left == 8'd1) state <= CHK;
                     end
                  end
                  default: begin
                     ok <= acc == rx_data;
                     tx_data <= acc == rx_data ? ACK_BYTE : NAK_BYTE;
                     tx_valid <= 1'b1;
                     state <= RESP;
                  end
               endcase
            end else if (tmo) begin
               ok <= 1'b0;
               tx_data <= NAK_BYTE;
               tx_valid <= 1'b1;
               state <= RESP;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_loader_ctrl.sv
// tb_uart_loader_ctrl: scoreboard bench for the UART boot loader
module tb_uart_loader_ctrl;
   logic clk = 1'b0;
   logic rst, rx_valid, tx_ready, tx_valid, mem_we, cpu_hold, busy, done, err;
   logic [7:0] rx_data, tx_data;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   int passed = 0, total = 0;
   logic [47:0] wr_q[$];
   logic [7:0] tx_q[$];
   logic [47:0] wexp;
   logic [7:0] texp;
   logic [31:0] wbuf[256];

   uart_loader_ctrl #(.ADDR_W(16), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         total++;
         if (wr_q.size() == 0)
            $display("FAIL mem_write unexpected: addr=%h data=%h", mem_addr, mem_wdata);
         else begin
            wexp = wr_q.pop_front();
            if ({mem_addr, mem_wdata} !== wexp)
               $display("FAIL mem_write: got addr=%h data=%h, want addr=%h data=%h",
                        mem_addr, mem_wdata, wexp[47:32], wexp[31:0]);
            else passed++;
         end
      end
      if (tx_valid && tx_ready) begin
         total++;
         if (tx_q.size() == 0)
            $display("FAIL tx_handshake unexpected: tx_data=%h", tx_data);
         else begin
            texp = tx_q.pop_front();
            if ({tx_data, done, err} !== {texp, texp == 8'h4B, texp != 8'h4B})
               $display("FAIL tx_handshake: got data=%h done=%b err=%b, want data=%h done=%b err=%b",
                        tx_data, done, err, texp, texp == 8'h4B, texp != 8'h4B);
            else passed++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic send_frame(input logic [15:0] a, input logic [7:0] len, input bit bad);
      logic [7:0] chk;
      int n;
      n = (len == 8'd0) ? 256 : int'(len);
      chk = a[7:0] ^ a[15:8] ^ len;
      for (int i = 0; i < n; i++) begin
         chk ^= wbuf[i][7:0] ^ wbuf[i][15:8] ^ wbuf[i][23:16] ^ wbuf[i][31:24];
         wr_q.push_back({a + 16'(i), wbuf[i]});
      end
      tx_q.push_back(bad ? 8'h45 : 8'h4B);
      send_byte(8'hA5);
      total++;
      if (cpu_hold !== 1'b1 || busy !== 1'b1)
         $display("FAIL sync_hold: cpu_hold=%b busy=%b, want 1 1", cpu_hold, busy);
      else passed++;
      send_byte(a[7:0]);
      send_byte(a[15:8]);
      send_byte(len);
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 4; k++) begin
            send_byte(wbuf[i][8*k +: 8]);
            if ($urandom_range(0, 3) == 0) tick();
         end
      send_byte(bad ? 8'h00 : chk);
   endtask

   task automatic do_resp(input logic [7:0] expb, input bit with_rx);
      int t = 0;
      while (!tx_valid && t < 2000) begin
         tick();
         t++;
      end
      total++;
      if (tx_valid !== 1'b1) begin
         $display("FAIL resp_wait: tx_valid=%b after %0d cycles, want 1", tx_valid, t);
         return;
      end
      passed++;
      repeat (3) tick();
      total++;
      if ({tx_valid, tx_data, cpu_hold, busy, done, err} !== {1'b1, expb, 1'b1, 1'b1, 1'b0, 1'b0})
         $display("FAIL resp_hold: valid=%b data=%h hold=%b busy=%b done=%b err=%b, want 1 %h 1 1 0 0",
                  tx_valid, tx_data, cpu_hold, busy, done, err, expb);
      else passed++;
      tx_ready = 1'b1;
      if (with_rx) begin
         rx_valid = 1'b1;
         rx_data = 8'hA5;
      end
      tick();
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      total++;
      if ({tx_valid, cpu_hold, busy, done, err} !== 5'b0)
         $display("FAIL resp_release: valid=%b hold=%b busy=%b done=%b err=%b, want all 0",
                  tx_valid, cpu_hold, busy, done, err);
      else passed++;
      tick();
      total++;
      if ({busy, cpu_hold} !== 2'b0)
         $display("FAIL resp_idle: busy=%b hold=%b, want 0 0", busy, cpu_hold);
      else passed++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      tx_ready = 1'b0;
      repeat (2) tick();
      total++;
      if ({tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err} !== '0)
         $display("FAIL reset_state: outputs not all zero (valid=%b we=%b hold=%b busy=%b)",
                  tx_valid, mem_we, cpu_hold, busy);
      else passed++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_good;
      wbuf[0] = 32'h12345678;
      send_frame(16'h0010, 8'd1, 1'b0);
      do_resp(8'h4B, 1'b0);
   endtask

   task automatic test_bad_chk;
      wbuf[0] = 32'h12345678;
      send_frame(16'h0010, 8'd1, 1'b1);
      do_resp(8'h45, 1'b0);
   endtask

   task automatic test_wrap;
      wbuf[0] = 32'hDEADBEEF;
      wbuf[1] = 32'h0BADF00D;
      send_frame(16'hFFFF, 8'd2, 1'b0);
      do_resp(8'h4B, 1'b0);
   endtask

   task automatic test_idle_garbage;
      logic [7:0] g[4] = '{8'h00, 8'h1F, 8'h01, 8'h3E};
      for (int i = 0; i < 4; i++) begin
         send_byte(g[i]);
         total++;
         if ({busy, cpu_hold, tx_valid} !== 3'b0)
            $display("FAIL idle_ignore: byte=%h busy=%b hold=%b valid=%b, want 0 0 0",
                     g[i], busy, cpu_hold, tx_valid);
         else passed++;
      end
      for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
      send_frame(16'h0200, 8'd3, 1'b0);
      do_resp(8'h4B, 1'b0);
   endtask

   task automatic test_reset_mid;
      send_byte(8'hA5);
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h11);
      send_byte(8'h22);
      rst = 1'b1;
      tick();
      total++;
      if ({tx_valid, tx_data, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err} !== '0)
         $display("FAIL reset_mid: outputs not all zero (valid=%b we=%b hold=%b busy=%b)",
                  tx_valid, mem_we, cpu_hold, busy);
      else passed++;
      rst = 1'b0;
      repeat (3) tick();
      total++;
      if ({tx_valid, mem_we, busy} !== 3'b0)
         $display("FAIL reset_mid_quiet: valid=%b we=%b busy=%b, want 0 0 0", tx_valid, mem_we, busy);
      else passed++;
      wbuf[0] = 32'hCAFEF00D;
      send_frame(16'h0040, 8'd1, 1'b0);
      do_resp(8'h4B, 1'b0);
   endtask

   task automatic test_back_to_back;
      wbuf[0] = 32'hA5A5A5A5;
      wbuf[1] = 32'h00000001;
      send_frame(16'h1234, 8'd2, 1'b0);
      do_resp(8'h4B, 1'b1);
      wbuf[0] = 32'h55AA55AA;
      send_frame(16'h1300, 8'd1, 1'b0);
      do_resp(8'h4B, 1'b0);
   endtask

`ifdef LOADER_TIMEOUT_EN
   task automatic test_timeout;
      int t = 0;
      tx_q.push_back(8'h45);
      send_byte(8'hA5);
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h01);
      while (!tx_valid && t < 1000) begin
         tick();
         t++;
      end
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h45 || t < 95 || t > 105)
         $display("FAIL timeout: valid=%b data=%h after %0d cycles, want 1 45 near 100",
                  tx_valid, tx_data, t);
      else passed++;
      do_resp(8'h45, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_good();
      test_bad_chk();
      test_wrap();
      test_idle_garbage();
      test_reset_mid();
      test_back_to_back();
`ifdef LOADER_TIMEOUT_EN
      test_timeout();
`endif
      repeat (4) tick();
      total++;
      if (wr_q.size() != 0 || tx_q.size() != 0)
         $display("FAIL scoreboard_drain: writes left=%0d tx left=%0d, want 0 0", wr_q.size(), tx_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
